// File: rtl/hilo_result_if.sv
// hilo_result_if: bundle of the handshake, operand, divider and status signals
// between the execute cluster and hilo_result_stage.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer raising valid keeps it and its
// payload (funct on the input side, data_out on the output side) stable until
// the transfer. ready may depend combinationally on the payload. in_ready is
// one such case: it depends on funct.
interface hilo_result_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             div_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_pending;
  logic             err_illegal;
  logic             err_timeout;

  // Environment side: drives operands, divider results and writeback ready.
  modport master (
    output in_valid, funct, alu_out, shift_out, div_hi, div_lo, div_done,
           out_ready,
    input  in_ready, out_valid, data_out, hi_q, lo_q, div_pending,
           err_illegal, err_timeout
  );

  // Stage side.
  modport slave (
    input  in_valid, funct, alu_out, shift_out, div_hi, div_lo, div_done,
           out_ready,
    output in_ready, out_valid, data_out, hi_q, lo_q, div_pending,
           err_illegal, err_timeout
  );
endinterface

// File: rtl/hilo_result_stage.sv
// hilo_result_stage: registered result-select stage for the ALU / shifter /
// divider cluster. Holds the HI/LO registers, tracks one outstanding DIVU with
// a timeout, and interlocks MFHI/MFLO/DIVU against it.
// Optional feature macro: HILO_BYPASS_EN -- when defined, the HI/LO interlock
// is lifted in the div_done cycle and MFHI/MFLO read div_hi/div_lo directly.
module hilo_result_stage #(
  parameter int WIDTH       = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  hilo_result_if.slave bus
);

  localparam int CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  // Decoded view of the current funct.
  typedef struct packed {
    logic is_alu;
    logic is_srl;
    logic is_mfhi;
    logic is_mflo;
    logic is_divu;
    logic is_illegal;
  } dec_t;

  dec_t             dec;
  logic             hilo_op;
  logic             writes_back;
  logic             buf_free;
  logic             hilo_stall;
  logic             div_completing;
  logic             div_expiring;
  logic             accept;
  logic [WIDTH-1:0] wb_data;

  logic             out_valid_r;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             div_pending_r;
  logic [CW-1:0]    div_cnt;
  logic             err_illegal_r;
  logic             err_timeout_r;

  // Decode the function code into one-hot operation classes.
  always_comb begin
    dec = '0;
    unique case (bus.funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: dec.is_alu  = 1'b1;
      F_SRL:                            dec.is_srl  = 1'b1;
      F_MFHI:                           dec.is_mfhi = 1'b1;
      F_MFLO:                           dec.is_mflo = 1'b1;
      F_DIVU:                           dec.is_divu = 1'b1;
      default:                          dec.is_illegal = 1'b1;
    endcase
  end

  assign hilo_op        = dec.is_divu | dec.is_mfhi | dec.is_mflo;
  assign writes_back    = dec.is_alu | dec.is_srl | dec.is_mfhi | dec.is_mflo;
  assign div_completing = div_pending_r & bus.div_done;
  // Last counted cycle of a pending division with no completion in sight.
  assign div_expiring   = div_pending_r & ~bus.div_done & (div_cnt == CNT_LAST);
  assign buf_free       = ~out_valid_r | bus.out_ready;

`ifdef HILO_BYPASS_EN
  // The completing division's results are forwarded, so no stall that cycle.
  assign hilo_stall = div_pending_r & ~bus.div_done & hilo_op;
`else
  // Stall until HI/LO have actually been written (cycle after div_done).
  assign hilo_stall = div_pending_r & hilo_op;
`endif

  assign accept = bus.in_valid & buf_free & ~hilo_stall;

  // Select the writeback value for the accepted operation.
  always_comb begin
    wb_data = bus.alu_out;
    if (dec.is_srl) begin
      wb_data = bus.shift_out;
    end else if (dec.is_mfhi) begin
      wb_data = hi_r;
`ifdef HILO_BYPASS_EN
      if (div_completing) wb_data = bus.div_hi;
`endif
    end else if (dec.is_mflo) begin
      wb_data = lo_r;
`ifdef HILO_BYPASS_EN
      if (div_completing) wb_data = bus.div_lo;
`endif
    end
  end

  // Single-entry output buffer: load on writeback accept, drain on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      data_out_r  <= '0;
    end else if (accept && writes_back) begin
      out_valid_r <= 1'b1;
      data_out_r  <= wb_data;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // HI/LO registers and the outstanding-DIVU tracker with its timeout counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r          <= '0;
      lo_r          <= '0;
      div_pending_r <= 1'b0;
      div_cnt       <= '0;
    end else begin
      if (div_completing) begin
        hi_r          <= bus.div_hi;
        lo_r          <= bus.div_lo;
        div_pending_r <= 1'b0;
      end else if (div_expiring) begin
        div_pending_r <= 1'b0;
      end else if (div_pending_r && div_cnt != CNT_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end
      // A newly accepted DIVU overrides the clear of a completing one.
      if (accept && dec.is_divu) begin
        div_pending_r <= 1'b1;
        div_cnt       <= '0;
      end
    end
  end

  // One-cycle registered error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      err_illegal_r <= accept & dec.is_illegal;
      err_timeout_r <= div_expiring;
    end
  end

  assign bus.in_ready    = buf_free & ~hilo_stall;
  assign bus.out_valid   = out_valid_r;
  assign bus.data_out    = data_out_r;
  assign bus.hi_q        = hi_r;
  assign bus.lo_q        = lo_r;
  assign bus.div_pending = div_pending_r;
  assign bus.err_illegal = err_illegal_r;
  assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_hilo_result_stage.sv
// tb_hilo_result_stage: directed scenarios followed by random traffic, checked
// against a transaction-level reference model (writeback queue, HI/LO values,
// DIVU deadline expressed as an absolute edge number).
module tb_hilo_result_stage;

  localparam int W  = 32;
  localparam int TO = 8;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_result_if #(.WIDTH(W)) bus ();

  hilo_result_stage #(.WIDTH(W), .DIV_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit           m_pend = 1'b0;
  int unsigned  m_deadline = 0;
  bit           m_err_ill = 1'b0;
  bit           m_err_to = 1'b0;
  int unsigned  edge_no = 0;
  bit           last_acc = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at edge %0d", tag, got, exp, edge_no);
    end
  endtask

  function automatic bit is_wb_alu(input logic [5:0] f);
    return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
  endfunction

  // ---------------- driver + model step ----------------
  // Called at a falling edge: checks registered outputs, applies inputs for the
  // next rising edge, checks in_ready, advances the model, waits a cycle.
  task automatic step(input bit rn, input bit iv, input logic [5:0] f,
                      input logic [W-1:0] a, input logic [W-1:0] s,
                      input logic [W-1:0] dh, input logic [W-1:0] dl,
                      input bit dd, input bit ordy);
    bit hop, rdy, acc, done_now, expire;
    check("out_valid", bus.out_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) check("data_out", bus.data_out, exp_q[0]);
    check("hi_q", bus.hi_q, m_hi);
    check("lo_q", bus.lo_q, m_lo);
    check("div_pending", bus.div_pending, m_pend);
    check("err_illegal", bus.err_illegal, m_err_ill);
    check("err_timeout", bus.err_timeout, m_err_to);

    rst_n = rn;
    bus.in_valid = iv; bus.funct = f; bus.alu_out = a; bus.shift_out = s;
    bus.div_hi = dh; bus.div_lo = dl; bus.div_done = dd; bus.out_ready = ordy;
    #1;
    hop = (f == F_DIVU) || (f == F_MFHI) || (f == F_MFLO);
    done_now = m_pend && dd;
    rdy = (exp_q.size() == 0 || ordy) && !(m_pend && hop);
`ifdef HILO_BYPASS_EN
    if (done_now) rdy = (exp_q.size() == 0 || ordy);
`endif
    check("in_ready", bus.in_ready, rdy);
    acc = iv && rdy;
    last_acc = acc && rn;
    edge_no++;

    if (!rn) begin
      exp_q.delete();
      m_hi = '0; m_lo = '0; m_pend = 1'b0;
      m_err_ill = 1'b0; m_err_to = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      m_err_ill = 1'b0;
      if (acc) begin
        if (is_wb_alu(f)) exp_q.push_back(a);
        else if (f == F_SRL) exp_q.push_back(s);
        else if (f == F_MFHI) exp_q.push_back(done_now ? dh : m_hi);
        else if (f == F_MFLO) exp_q.push_back(done_now ? dl : m_lo);
        else if (f != F_DIVU) m_err_ill = 1'b1;
      end
      expire = m_pend && !dd && (edge_no == m_deadline);
      m_err_to = expire;
      if (done_now) begin
        m_hi = dh; m_lo = dl; m_pend = 1'b0;
      end else if (expire) begin
        m_pend = 1'b0;
      end
      if (acc && f == F_DIVU) begin
        m_pend = 1'b1;
        m_deadline = edge_no + TO;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b1, 1'b0, F_ADD, '0, '0, '0, '0, 1'b0, ordy);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ftab[9];
  int         n_to;

  initial begin
    ftab = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_DIVU, F_MFHI, F_MFLO};
    bus.in_valid = 1'b0; bus.funct = F_ADD; bus.alu_out = '0; bus.shift_out = '0;
    bus.div_hi = '0; bus.div_lo = '0; bus.div_done = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset: everything zero, with junk on the inputs.
    step(1'b0, 1'b1, F_ADD, 32'h1234, 32'h5678, 32'h9, 32'h9, 1'b1, 1'b1);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_out_valid", bus.out_valid, 32'h0);
    check("rst_hi_q", bus.hi_q, 32'h0);

    // ADD result appears one cycle after accept.
    step(1'b1, 1'b1, F_ADD, 32'h0000_0005, '0, '0, '0, 1'b0, 1'b1);
    check("add_data", bus.data_out, 32'h5);
    check("add_valid", bus.out_valid, 32'h1);
    idle(1'b1);

    // SRL held under backpressure, then released.
    step(1'b1, 1'b1, F_SRL, 32'hdead, 32'h0F00_0000, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, F_AND, 32'h77, '0, '0, '0, 1'b0, 1'b0);
      check("srl_hold", bus.data_out, 32'h0F00_0000);
    end
    idle(1'b1);
    check("srl_drained", bus.out_valid, 32'h0);

    // DIVU, OR flows past it, MFLO stalls until the division completes.
    step(1'b1, 1'b1, F_DIVU, '0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, F_OR, 32'h55, '0, '0, '0, 1'b0, 1'b1);
    check("or_data", bus.data_out, 32'h55);
    step(1'b1, 1'b1, F_MFLO, '0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, F_MFLO, '0, '0, 32'd3, 32'd7, 1'b1, 1'b1);
    check("div_hi_q", bus.hi_q, 32'd3);
    check("div_lo_q", bus.lo_q, 32'd7);
`ifdef HILO_BYPASS_EN
    check("mflo_bypass", bus.data_out, 32'd7);
`endif
    step(1'b1, 1'b1, F_MFLO, '0, '0, '0, '0, 1'b0, 1'b1);
    check("mflo_data", bus.data_out, 32'd7);
    idle(1'b1);

    // DIVU with no completion times out once.
    step(1'b1, 1'b1, F_DIVU, '0, '0, '0, '0, 1'b0, 1'b1);
    n_to = 0;
    for (int i = 0; i < TO + 2; i++) begin
      idle(1'b1);
      if (bus.err_timeout) n_to++;
    end
    check("timeout_pulses", n_to, 32'd1);
    check("timeout_pend", bus.div_pending, 32'd0);
    check("timeout_hi", bus.hi_q, 32'd3);

    // Illegal funct and a stray div_done.
    step(1'b1, 1'b1, 6'b111111, 32'h1, '0, '0, '0, 1'b0, 1'b1);
    check("illegal_pulse", bus.err_illegal, 32'd1);
    check("illegal_nowb", bus.out_valid, 32'd0);
    step(1'b1, 1'b0, F_ADD, '0, '0, 32'h99, 32'h98, 1'b1, 1'b1);
    check("illegal_drop", bus.err_illegal, 32'd0);
    check("stray_done_hi", bus.hi_q, 32'd3);
    check("stray_done_lo", bus.lo_q, 32'd7);

    // Reset during a pending division; later div_done is ignored.
    step(1'b1, 1'b1, F_DIVU, '0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, F_ADD, '0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, F_ADD, '0, '0, 32'h11, 32'h22, 1'b1, 1'b1);
    check("rst_div_pend", bus.div_pending, 32'd0);
    check("rst_div_hi", bus.hi_q, 32'd0);
    check("rst_div_lo", bus.lo_q, 32'd0);

    // Random traffic; funct is held while a request waits.
    begin
      bit         iv;
      logic [5:0] f;
      iv = 1'b0; f = F_ADD;
      for (int i = 0; i < 3000; i++) begin
        if (!(iv && !last_acc)) begin
          iv = ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
          else f = ftab[$urandom_range(0, 8)];
        end
        step(($urandom_range(0, 499) != 0), iv, f, $urandom, $urandom,
             $urandom, $urandom, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_result_stage.md
# hilo_result_stage

Registered, parametrised result-select stage for the MIPS datapath's ALU/shifter/divider cluster. It accepts one decoded R-type function code per handshake and registers the selected result (ALU, shifter, HI or LO) into a single-entry output buffer with valid/ready flow control. It also owns the HI/LO architectural registers, tracks an outstanding DIVU, and interlocks MFHI/MFLO against it. It sits between the execute units and the register-file writeback port.

## Interface
- WIDTH, 32, datapath width of every data port and of HI/LO
- DIV_TIMEOUT, 64, max cycles a DIVU may stay outstanding before abort (>=2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  function code and operands valid
- in_ready  output  1  stage accepts this cycle
- funct  input  6  AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, DIVU 011011, MFHI 010000, MFLO 010010
- alu_out  input  WIDTH  ALU result
- shift_out  input  WIDTH  shifter result
- div_hi / div_lo  input  WIDTH  divider remainder / quotient
- div_done  input  1  one-cycle divider completion strobe
- out_valid  output  1  data_out holds a writeback result
- out_ready  input  1  writeback consumes data_out
- data_out  output  WIDTH  registered result
- hi_q / lo_q  output  WIDTH  current HI / LO
- div_pending  output  1  DIVU outstanding
- err_illegal  output  1  one-cycle pulse: unknown funct accepted
- err_timeout  output  1  one-cycle pulse: DIVU aborted

## Operation
- Reset (rst_n=0 at an edge): out_valid, data_out, hi_q, lo_q, div_pending, timeout counter, err_* all 0. Reset mid-division drops the pending DIVU; a later div_done is ignored.
- buf_free = !out_valid || out_ready.
- hilo_op = funct is DIVU, MFHI or MFLO.
- in_ready = buf_free && !(div_pending && hilo_op). in_ready depends combinationally on funct; upstream must hold funct stable while in_valid=1.
- Accept = in_valid && in_ready:
  - AND/OR/ADD/SUB/SLT: data_out<=alu_out, out_valid<=1.
  - SRL: data_out<=shift_out, out_valid<=1.
  - MFHI / MFLO: data_out<=hi_q / lo_q, out_valid<=1.
  - DIVU: div_pending<=1, counter<=0; no writeback; out_valid<=0 if out_ready, else held.
  - Other funct: no writeback; err_illegal pulses next cycle.
- No accept and out_ready=1: out_valid<=0. data_out holds its value whenever out_valid=1 && out_ready=0.
- While div_pending, non-HI/LO ops keep flowing.
- div_pending=1 and div_done=1: hi_q<=div_hi, lo_q<=div_lo, div_pending<=0.
- div_done while div_pending=0 (including the DIVU accept cycle): ignored.
- Counter increments each pending cycle without div_done. When it reaches DIV_TIMEOUT-1 without div_done: div_pending<=0, HI/LO unchanged, err_timeout pulses. div_done in that same cycle wins: it completes normally, no error.
- Counter width: $clog2(DIV_TIMEOUT); it saturates and cannot wrap.

## Timing
- Accept-to-out_valid latency: 1 cycle. Full throughput is 1 result/cycle when out_ready=1.
- div_done-to-hi_q/lo_q update: 1 cycle.
- MFHI/MFLO stalled by a pending DIVU is accepted no earlier than the cycle after div_done (no bypass). Its data_out appears 1 cycle after that.
- err_* pulses are high for exactly 1 cycle, registered.
- Back-to-back DIVU: the second stalls until the first completes or times out.

## Configuration
- HILO_BYPASS_EN defined:
  - In the div_done cycle, an MFHI/MFLO/DIVU is not stalled.
  - MFHI/MFLO accepted then take div_hi/div_lo directly.
  - A DIVU accepted then starts a new pending division, and the completing one still updates HI/LO.
- HILO_BYPASS_EN undefined: the stall persists through the div_done cycle, as in Operation.

## Test plan
- Reset, then ADD with alu_out=0x0000_0005, out_ready=1 -> next cycle out_valid=1, data_out=5; all outputs 0 during reset.
- SRL with shift_out=0x0F00_0000 while out_ready=0 for 3 cycles -> data_out held at 0x0F00_0000, in_ready=0; out_ready=1 releases the entry and frees the buffer.
- DIVU, then OR (accepted, result written), then MFLO stalled; div_done with div_hi=3, div_lo=7 -> hi_q=3, lo_q=7; MFLO accepted next cycle, data_out=7 one cycle later (with bypass: accepted in the div_done cycle, data_out=7).
- DIVU with no div_done, DIV_TIMEOUT=8 -> err_timeout pulses once, div_pending=0 after 8 cycles, hi_q/lo_q unchanged.
- funct=6'b111111 accepted -> err_illegal 1-cycle pulse, out_valid stays 0. Stray div_done with no pending DIVU -> hi_q/lo_q unchanged.
- rst_n=0 during a pending DIVU, then div_done -> div_pending=0, hi_q=lo_q=0.
